// File: rtl/four_aoi_pkg.sv
// Shared constants for the four_aoi block: default lane count and per-lane reset values.
package four_aoi_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Reset values for a single lane; g resets to the AOI of all-zero inputs.
    localparam logic E_RST = 1'b0;
    localparam logic F_RST = 1'b0;
    localparam logic G_RST = 1'b1;

endpackage

// File: rtl/four_aoi_aoi_cell.sv
// Single-lane combinational AND-OR-INVERT cell: two AND terms and their NOR.
module aoi_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic and_ab,
    output logic and_cd,
    output logic aoi
);

    assign and_ab = a & b;
    assign and_cd = c & d;
    assign aoi    = ~(and_ab | and_cd);

endmodule

// File: rtl/four_aoi.sv
// WIDTH independent AOI lanes with registered outputs and a one-cycle valid pipeline.
module four_aoi
    import four_aoi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic             out_valid
);

    logic [WIDTH-1:0] e_next;
    logic [WIDTH-1:0] f_next;
    logic [WIDTH-1:0] g_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        aoi_cell u_cell (
            .a      (a[i]),
            .b      (b[i]),
            .c      (c[i]),
            .d      (d[i]),
            .and_ab (e_next[i]),
            .and_cd (f_next[i]),
            .aoi    (g_next[i])
        );
    end

    // Data registers only load on qualified cycles; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            e <= {WIDTH{E_RST}};
            f <= {WIDTH{F_RST}};
            g <= {WIDTH{G_RST}};
        end else if (in_valid) begin
            e <= e_next;
            f <= f_next;
            g <= g_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_four_aoi.sv
// Self-checking bench for four_aoi at WIDTH=1 and WIDTH=4 against a behavioural model.
module tb_four_aoi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       v1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, c1 = '0, d1 = '0;
    logic [0:0] e1, f1, g1;
    logic       ov1;

    logic       v4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, c4 = '0, d4 = '0;
    logic [3:0] e4, f4, g4;
    logic       ov4;

    // Model state: what each DUT should show after the most recent edge.
    logic [0:0] m_e1 = '0, m_f1 = '0, m_g1 = '1;
    logic       m_ov1 = 1'b0;
    logic [3:0] m_e4 = '0, m_f4 = '0, m_g4 = '1;
    logic       m_ov4 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    four_aoi #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .d         (d1),
        .e         (e1),
        .f         (f1),
        .g         (g1),
        .out_valid (ov1)
    );

    four_aoi #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .c         (c4),
        .d         (d4),
        .e         (e4),
        .f         (f4),
        .g         (g4),
        .out_valid (ov4)
    );

    // Lane rule from counts: a term is true when both of its operands are 1,
    // and the inverted result is true when no term is true.
    function automatic logic [2:0] lane_rule(input int pa, input int pb, input int pc, input int pd);
        int ab_ones = pa + pb;
        int cd_ones = pc + pd;
        int terms   = (ab_ones == 2 ? 1 : 0) + (cd_ones == 2 ? 1 : 0);
        return {ab_ones == 2, cd_ones == 2, terms == 0};
    endfunction

    // Advance the model with the inputs present before the edge, then wait one clock.
    task automatic tick();
        logic [2:0] r;
        if (rst) begin
            m_e1 = '0; m_f1 = '0; m_g1 = '1; m_ov1 = 1'b0;
            m_e4 = '0; m_f4 = '0; m_g4 = '1; m_ov4 = 1'b0;
        end else begin
            m_ov1 = v1;
            m_ov4 = v4;
            if (v1) begin
                r = lane_rule(int'(a1[0]), int'(b1[0]), int'(c1[0]), int'(d1[0]));
                m_e1[0] = r[2]; m_f1[0] = r[1]; m_g1[0] = r[0];
            end
            if (v4) begin
                for (int i = 0; i < 4; i++) begin
                    r = lane_rule(int'(a4[i]), int'(b4[i]), int'(c4[i]), int'(d4[i]));
                    m_e4[i] = r[2]; m_f4[i] = r[1]; m_g4[i] = r[0];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand4();
        v4 = 1'($urandom_range(0, 1));
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom); d4 = 4'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b1; a1 = '1; b1 = '1; c1 = '1; d1 = '1;
        v4 = 1'b1; a4 = '1; b4 = '1; c4 = '1; d4 = '1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({e1, f1, g1, ov1} !== 4'b0010) begin
                errors++;
                $display("FAIL reset_w1 cycle %0d: efgv=%b expected 0010", k, {e1, f1, g1, ov1});
            end
            checks++;
            if ({e4, f4, g4, ov4} !== {4'h0, 4'h0, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL reset_w4 cycle %0d: e=%b f=%b g=%b v=%b expected 0000/0000/1111/0",
                         k, e4, f4, g4, ov4);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({e1, f1, g1, ov1} !== 4'b1101) begin
            errors++;
            $display("FAIL release_w1: efgv=%b expected 1101", {e1, f1, g1, ov1});
        end
        checks++;
        if ({e4, f4, g4, ov4} !== {4'hF, 4'hF, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL release_w4: e=%b f=%b g=%b v=%b expected 1111/1111/0000/1", e4, f4, g4, ov4);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] pat;
        for (int i = 0; i < 16; i++) begin
            pat = 4'(i);
            v1 = 1'b1;
            {a1[0], b1[0], c1[0], d1[0]} = pat;
            rand4();
            tick();
            checks++;
            if ({e1, f1, g1, ov1} !== {m_e1, m_f1, m_g1, m_ov1}) begin
                errors++;
                $display("FAIL sweep abcd=%b: efgv=%b expected %b", pat,
                         {e1, f1, g1, ov1}, {m_e1, m_f1, m_g1, m_ov1});
            end
            checks++;
            if ({e4, f4, g4, ov4} !== {m_e4, m_f4, m_g4, m_ov4}) begin
                errors++;
                $display("FAIL sweep_w4 step %0d: efgv=%b expected %b", i,
                         {e4, f4, g4, ov4}, {m_e4, m_f4, m_g4, m_ov4});
            end
        end
    endtask

    task automatic test_hold();
        v1 = 1'b1; {a1[0], b1[0], c1[0], d1[0]} = 4'b0011;
        tick();
        v1 = 1'b0; {a1[0], b1[0], c1[0], d1[0]} = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({e1, f1, g1, ov1} !== 4'b0100) begin
                errors++;
                $display("FAIL hold cycle %0d: efgv=%b expected 0100", k, {e1, f1, g1, ov1});
            end
        end
    endtask

    task automatic test_multilane();
        v4 = 1'b1;
        a4 = 4'b1010; b4 = 4'b1100; c4 = 4'b0110; d4 = 4'b0011;
        tick();
        checks++;
        if ({e4, f4, g4, ov4} !== {4'b1000, 4'b0010, 4'b0101, 1'b1}) begin
            errors++;
            $display("FAIL multilane: e=%b f=%b g=%b v=%b expected 1000/0010/0101/1", e4, f4, g4, ov4);
        end
    endtask

    task automatic test_toggle();
        for (int cyc = 0; cyc < 16; cyc++) begin
            v1 = 1'b1;
            d1[0] = cyc[0]; c1[0] = cyc[1]; b1[0] = cyc[2]; a1[0] = cyc[3];
            v4 = 1'b1;
            d4 = {4{cyc[0]}}; c4 = {4{cyc[1]}}; b4 = {4{cyc[2]}}; a4 = {4{cyc[3]}};
            tick();
            checks++;
            if ({e1, f1, g1, ov1} !== {m_e1, m_f1, m_g1, m_ov1}) begin
                errors++;
                $display("FAIL toggle cycle %0d: efgv=%b expected %b", cyc,
                         {e1, f1, g1, ov1}, {m_e1, m_f1, m_g1, m_ov1});
            end
            checks++;
            if ({e4, f4, g4, ov4} !== {m_e4, m_f4, m_g4, m_ov4}) begin
                errors++;
                $display("FAIL toggle_w4 cycle %0d: efgv=%b expected %b", cyc,
                         {e4, f4, g4, ov4}, {m_e4, m_f4, m_g4, m_ov4});
            end
        end
    endtask

    task automatic test_midstream_reset();
        v1 = 1'b1; {a1[0], b1[0], c1[0], d1[0]} = 4'b1111;
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 4'h3; d4 = 4'h5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v1 = 1'b0; v4 = 1'b0;
        tick();
        checks++;
        if ({e1, f1, g1, ov1} !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_w1: efgv=%b expected 0010", {e1, f1, g1, ov1});
        end
        checks++;
        if ({e4, f4, g4, ov4} !== {4'h0, 4'h0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL midreset_w4: e=%b f=%b g=%b v=%b expected 0000/0000/1111/0", e4, f4, g4, ov4);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 19) == 0);
            v1 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); d1 = 1'($urandom);
            rand4();
            tick();
            checks++;
            if ({e1, f1, g1, ov1} !== {m_e1, m_f1, m_g1, m_ov1}) begin
                errors++;
                $display("FAIL random_w1 step %0d: efgv=%b expected %b", n,
                         {e1, f1, g1, ov1}, {m_e1, m_f1, m_g1, m_ov1});
            end
            checks++;
            if ({e4, f4, g4, ov4} !== {m_e4, m_f4, m_g4, m_ov4}) begin
                errors++;
                $display("FAIL random_w4 step %0d: efgv=%b expected %b", n,
                         {e4, f4, g4, ov4}, {m_e4, m_f4, m_g4, m_ov4});
            end
            checks++;
            if ((e4 & f4 & g4) !== 4'h0 || (g4 & (e4 | f4)) !== 4'h0) begin
                errors++;
                $display("FAIL random_excl step %0d: e=%b f=%b g=%b", n, e4, f4, g4);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_exhaustive();
        test_hold();
        test_multilane();
        test_toggle();
        test_midstream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_aoi.md
FOUR_AOI -- requirements
Module: four_aoi

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent bit lanes in every data port.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; sampled only on the rising edge of clk.
REQ-004 in_valid  input  1  qualifies a, b, c and d in the current cycle.
REQ-005 a  input  WIDTH  first operand of the first AND term.
REQ-006 b  input  WIDTH  second operand of the first AND term.
REQ-007 c  input  WIDTH  first operand of the second AND term.
REQ-008 d  input  WIDTH  second operand of the second AND term.
REQ-009 e  output  WIDTH  registered a AND b.
REQ-010 f  output  WIDTH  registered c AND d.
REQ-011 g  output  WIDTH  registered NOT(e_next OR f_next), i.e. the AND-OR-INVERT result.
REQ-012 out_valid  output  1  high when e, f and g hold a result from a qualified input.

Function
REQ-013 The block SHALL operate bitwise per lane i: e[i]=a[i]&b[i], f[i]=c[i]&d[i], g[i]=~((a[i]&b[i])|(c[i]&d[i])); lanes SHALL have no cross-lane interaction.
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N appear on e/f/g after edge N.
REQ-015 e, f and g SHALL update only on edges where in_valid=1 and rst=0; otherwise they SHALL hold their previous values.
REQ-016 out_valid SHALL be a one-cycle-delayed copy of in_valid (set to 0 when rst=1), with no backpressure.
REQ-017 Outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-018 For every lane, e and f SHALL never both be 1 while g=1; g=1 SHALL hold exactly when e=0 and f=0 for the same captured inputs.
REQ-019 X/Z handling SHALL not be required; inputs are 2-state.

Reset
REQ-020 When rst=1 at a rising edge: e=0, f=0, g=all ones (the all-zero-input result), out_valid=0.
REQ-021 Reset SHALL take priority over in_valid on the same edge.
REQ-022 The first qualified input after reset release SHALL be captured normally on the next edge.
REQ-023 Reset asserted mid-stream SHALL discard any in-flight result.

Structure
REQ-024 Shared package four_aoi_pkg SHALL hold DEFAULT_WIDTH=1 and the reset constants E_RST=0, F_RST=0, G_RST=1 (replicated per lane).
REQ-025 One combinational sub-module, aoi_cell, SHALL be used:
- ports a, b, c, d in; and_ab, and_cd, aoi out.
- instantiated WIDTH times by generate.
REQ-026 four_aoi SHALL contain only the generate loop, the output/valid registers and reset logic.

Verification
REQ-027 Exhaustive sweep with WIDTH=1 and in_valid=1 over all 16 combinations of {a,b,c,d}, each held one cycle -> one cycle later e=a&b, f=c&d, g=~(e|f); e.g. 1100 -> e=1,f=0,g=0, 0000 -> 0,0,1, 1111 -> 1,1,0.
REQ-028 Reset check: rst=1 for 2 edges with a=b=c=d=1 and in_valid=1 -> e=0, f=0, g=1, out_valid=0; release -> next edge gives e=1, f=1, g=0, out_valid=1.
REQ-029 Hold check: capture 0011, then drop in_valid and apply 1100 -> e=0, f=1, g=0 persist and out_valid=0.
REQ-030 Multi-lane check with WIDTH=4: a=4'b1010, b=4'b1100, c=4'b0110, d=4'b0011 -> e=4'b1000, f=4'b0010, g=4'b0101.
REQ-031 Toggle stimulus with d flipping every cycle, c every 2, b every 4 and a every 8 cycles, 16 cycles -> every cycle output matches REQ-013 applied to the previous cycle's inputs.
